// File: rtl/rv23_operand_fetch.sv
// rv23_operand_fetch: register-read/issue stage with busy-bit scoreboard, writeback bypass and one-entry output register
module rv23_operand_fetch #(
  parameter int ADDRESS_BITWIDTH = 5,
  parameter int DATA_WIDTH       = 32,
  parameter int CTRL_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDRESS_BITWIDTH-1:0] in_rs1,
  input  logic [ADDRESS_BITWIDTH-1:0] in_rs2,
  input  logic                        in_use_rs1,
  input  logic                        in_use_rs2,
  input  logic [ADDRESS_BITWIDTH-1:0] in_rd,
  input  logic                        in_rd_we,
  input  logic [DATA_WIDTH-1:0]       in_imm,
  input  logic [DATA_WIDTH-1:0]       in_pc,
  input  logic [CTRL_WIDTH-1:0]       in_ctrl,
  output logic [ADDRESS_BITWIDTH-1:0] rf_rs1,
  output logic [ADDRESS_BITWIDTH-1:0] rf_rs2,
  input  logic [DATA_WIDTH-1:0]       rf_rd1,
  input  logic [DATA_WIDTH-1:0]       rf_rd2,
  input  logic                        wb_valid,
  input  logic [ADDRESS_BITWIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]       wb_data,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_op1,
  output logic [DATA_WIDTH-1:0]       out_op2,
  output logic [DATA_WIDTH-1:0]       out_imm,
  output logic [DATA_WIDTH-1:0]       out_pc,
  output logic [ADDRESS_BITWIDTH-1:0] out_rd,
  output logic                        out_rd_we,
  output logic [CTRL_WIDTH-1:0]       out_ctrl,
  output logic [31:0]                 stall_cnt
);
  localparam int NUM_REGS = 1 << ADDRESS_BITWIDTH;
  logic [NUM_REGS-1:0]         busy_q, busy_d, busy_eff, wb_clr, rd_set;
  logic                        out_valid_q, out_valid_d, out_rd_we_q, out_rd_we_d;
  logic [DATA_WIDTH-1:0]       out_op1_q, out_op1_d, out_op2_q, out_op2_d;
  logic [DATA_WIDTH-1:0]       out_imm_q, out_imm_d, out_pc_q, out_pc_d;
  logic [ADDRESS_BITWIDTH-1:0] out_rd_q, out_rd_d;
  logic [CTRL_WIDTH-1:0]       out_ctrl_q, out_ctrl_d;
  logic [31:0]                 stall_cnt_q, stall_cnt_d;
  logic                        hz, fire;
  logic [DATA_WIDTH-1:0]       op1, op2;
  always_comb begin
    wb_clr   = wb_valid ? (NUM_REGS'(1) << wb_rd) : '0;
    busy_eff = busy_q & ~wb_clr;
    hz = in_valid & ((in_use_rs1 & (in_rs1 != '0) & busy_eff[in_rs1]) |
                     (in_use_rs2 & (in_rs2 != '0) & busy_eff[in_rs2]) |
                     (in_rd_we   & (in_rd  != '0) & busy_eff[in_rd]));
    in_ready = ~hz & ~flush & (~out_valid_q | out_ready);
    fire     = in_valid & in_ready;
    // Writeback data lands in the regfile only at the edge, so forward it this cycle
    op1 = (~in_use_rs1 | in_rs1 == '0) ? '0 : (wb_valid & wb_rd == in_rs1) ? wb_data : rf_rd1;
    op2 = (~in_use_rs2 | in_rs2 == '0) ? '0 : (wb_valid & wb_rd == in_rs2) ? wb_data : rf_rd2;
    rd_set = (fire & in_rd_we & in_rd != '0) ? (NUM_REGS'(1) << in_rd) : '0;
    busy_d = flush ? '0 : (((busy_q & ~wb_clr) | rd_set) & ~NUM_REGS'(1));
    out_valid_d = flush ? 1'b0 : fire ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    out_op1_d   = fire ? op1      : out_op1_q;
    out_op2_d   = fire ? op2      : out_op2_q;
    out_imm_d   = fire ? in_imm   : out_imm_q;
    out_pc_d    = fire ? in_pc    : out_pc_q;
    out_rd_d    = fire ? in_rd    : out_rd_q;
    out_rd_we_d = fire ? in_rd_we : out_rd_we_q;
    out_ctrl_d  = fire ? in_ctrl  : out_ctrl_q;
    stall_cnt_d = (hz & ~&stall_cnt_q) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_imm_q   <= '0;
      out_pc_q    <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
      out_ctrl_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      out_imm_q   <= out_imm_d;
      out_pc_q    <= out_pc_d;
      out_rd_q    <= out_rd_d;
      out_rd_we_q <= out_rd_we_d;
      out_ctrl_q  <= out_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign rf_rs1    = in_rs1;
  assign rf_rs2    = in_rs2;
  assign out_valid = out_valid_q;
  assign out_op1   = out_op1_q;
  assign out_op2   = out_op2_q;
  assign out_imm   = out_imm_q;
  assign out_pc    = out_pc_q;
  assign out_rd    = out_rd_q;
  assign out_rd_we = out_rd_we_q;
  assign out_ctrl  = out_ctrl_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_rv23_operand_fetch.sv
// tb_rv23_operand_fetch: directed scenario tests for rv23_operand_fetch
module tb_rv23_operand_fetch;
  logic        clk = 1'b0, reset;
  logic        in_valid, in_ready, in_use_rs1, in_use_rs2, in_rd_we;
  logic [4:0]  in_rs1, in_rs2, in_rd, rf_rs1, rf_rs2, wb_rd, out_rd;
  logic [31:0] in_imm, in_pc, rf_rd1, rf_rd2, wb_data;
  logic [15:0] in_ctrl, out_ctrl;
  logic        wb_valid, flush, out_valid, out_ready, out_rd_we;
  logic [31:0] out_op1, out_op2, out_imm, out_pc, stall_cnt;
  int          n_run = 0, n_fail = 0;
  logic [31:0] exp_stall = 0;
  always #5 clk = ~clk;
  rv23_operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_imm(in_imm), .in_pc(in_pc), .in_ctrl(in_ctrl),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_imm(out_imm), .out_pc(out_pc), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );
  task automatic idle();
    in_valid = 0; in_use_rs1 = 0; in_use_rs2 = 0; in_rd_we = 0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_imm = 0; in_pc = 0; in_ctrl = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; flush = 0;
  endtask
  task automatic edge_wait();
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    reset = 0; idle(); out_ready = 1; rf_rd1 = 0; rf_rd2 = 0;
    in_valid = 1; in_rd = 4; in_rd_we = 1; flush = 1;
    edge_wait(); edge_wait();
    @(negedge clk); reset = 1; idle(); #1;
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_run++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    n_run++; if (out_op1 !== 32'd0 || out_rd !== 5'd0 || out_ctrl !== 16'd0) begin n_fail++; $display("FAIL reset_out_data op1=%h rd=%0d ctrl=%h want 0", out_op1, out_rd, out_ctrl); end
  endtask
  task automatic test_raw_bypass();
    @(negedge clk); idle(); in_valid = 1; in_rd = 5; in_rd_we = 1; in_pc = 32'h100; in_ctrl = 16'h00AA; #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_prod_ready got %0b want 1", in_ready); end
    edge_wait();
    n_run++; if (out_valid !== 1'b1 || out_rd !== 5'd5 || out_rd_we !== 1'b1 || out_pc !== 32'h100 || out_ctrl !== 16'h00AA)
      begin n_fail++; $display("FAIL raw_prod_out v=%0b rd=%0d we=%0b pc=%h ctrl=%h want 1/5/1/100/00aa", out_valid, out_rd, out_rd_we, out_pc, out_ctrl); end
    @(negedge clk); idle(); in_valid = 1; in_rs1 = 5; in_use_rs1 = 1; rf_rd1 = 32'h1111; #1;
    n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_ready got %0b want 0", in_ready); end
    n_run++; if (rf_rs1 !== 5'd5) begin n_fail++; $display("FAIL raw_rf_rs1 got %0d want 5", rf_rs1); end
    edge_wait(); exp_stall = exp_stall + 1;
    n_run++; if (stall_cnt !== exp_stall || out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_stall_cnt cnt=%0d v=%0b want %0d/0", stall_cnt, out_valid, exp_stall); end
    @(negedge clk); wb_valid = 1; wb_rd = 5; wb_data = 32'h32; #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_wb_ready got %0b want 1", in_ready); end
    edge_wait();
    n_run++; if (out_valid !== 1'b1 || out_op1 !== 32'h32 || stall_cnt !== exp_stall) begin n_fail++; $display("FAIL raw_bypass v=%0b op1=%h cnt=%0d want 1/32/%0d", out_valid, out_op1, stall_cnt, exp_stall); end
    @(negedge clk); idle(); edge_wait();
  endtask
  task automatic test_zero_reg();
    @(negedge clk); idle(); in_valid = 1; in_rs1 = 0; in_use_rs1 = 1; rf_rd1 = 32'hDEADBEEF;
    in_rs2 = 3; in_use_rs2 = 1; rf_rd2 = 32'h33; in_rd = 0; in_rd_we = 1; #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready got %0b want 1", in_ready); end
    edge_wait();
    n_run++; if (out_op1 !== 32'd0 || out_op2 !== 32'h33) begin n_fail++; $display("FAIL zero_ops op1=%h op2=%h want 0/33", out_op1, out_op2); end
    @(negedge clk); in_use_rs2 = 0; in_rs1 = 0; #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_waw_ready got %0b want 1", in_ready); end
    edge_wait();
    n_run++; if (out_op2 !== 32'd0 || stall_cnt !== exp_stall) begin n_fail++; $display("FAIL zero_unused op2=%h cnt=%0d want 0/%0d", out_op2, stall_cnt, exp_stall); end
    @(negedge clk); idle(); edge_wait();
  endtask
  task automatic test_backpressure();
    @(negedge clk); idle(); out_ready = 0; in_valid = 1; in_imm = 32'hA; in_pc = 32'h200;
    edge_wait();
    @(negedge clk); in_imm = 32'hB; in_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %0b want 0", i, in_ready); end
      edge_wait();
      n_run++; if (out_valid !== 1'b1 || out_imm !== 32'hA || out_pc !== 32'h200) begin n_fail++; $display("FAIL bp_hold[%0d] v=%0b imm=%h pc=%h want 1/a/200", i, out_valid, out_imm, out_pc); end
      @(negedge clk);
    end
    out_ready = 1; #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %0b want 1", in_ready); end
    edge_wait();
    n_run++; if (out_valid !== 1'b1 || out_imm !== 32'hB || out_pc !== 32'h204) begin n_fail++; $display("FAIL bp_next v=%0b imm=%h pc=%h want 1/b/204", out_valid, out_imm, out_pc); end
    @(negedge clk); idle(); edge_wait();
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %0b want 0", out_valid); end
  endtask
  task automatic test_flush();
    @(negedge clk); idle(); in_valid = 1; in_rd = 7; in_rd_we = 1;
    edge_wait();
    @(negedge clk); idle(); in_valid = 1; in_rs2 = 7; in_use_rs2 = 1; rf_rd2 = 32'h77; #1;
    n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_stall_ready got %0b want 0", in_ready); end
    edge_wait(); exp_stall = exp_stall + 1;
    @(negedge clk); flush = 1; wb_valid = 1; wb_rd = 3; wb_data = 32'h5; #1;
    n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %0b want 0", in_ready); end
    edge_wait(); exp_stall = exp_stall + 1;
    n_run++; if (out_valid !== 1'b0 || stall_cnt !== exp_stall) begin n_fail++; $display("FAIL flush_out v=%0b cnt=%0d want 0/%0d", out_valid, stall_cnt, exp_stall); end
    @(negedge clk); flush = 0; wb_valid = 0; #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_busy_clr ready=%0b want 1", in_ready); end
    edge_wait();
    n_run++; if (out_valid !== 1'b1 || out_op2 !== 32'h77) begin n_fail++; $display("FAIL flush_consumer v=%0b op2=%h want 1/77", out_valid, out_op2); end
    @(negedge clk); idle(); edge_wait();
  endtask
  task automatic test_set_wins_and_reset();
    @(negedge clk); idle(); in_valid = 1; in_rd = 9; in_rd_we = 1;
    edge_wait();
    @(negedge clk); wb_valid = 1; wb_rd = 9; wb_data = 32'h99; in_imm = 32'h9; #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL setwin_ready got %0b want 1", in_ready); end
    edge_wait();
    @(negedge clk); idle(); in_valid = 1; in_rs1 = 9; in_use_rs1 = 1; rf_rd1 = 32'h123; #1;
    n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL setwin_busy ready=%0b want 0", in_ready); end
    edge_wait(); edge_wait(); exp_stall = exp_stall + 2;
    n_run++; if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL setwin_cnt got %0d want %0d", stall_cnt, exp_stall); end
    @(negedge clk); reset = 0;
    edge_wait();
    n_run++; if (out_valid !== 1'b0 || stall_cnt !== 32'd0 || out_pc !== 32'd0 || out_rd !== 5'd0 || out_imm !== 32'd0)
      begin n_fail++; $display("FAIL midreset v=%0b cnt=%0d pc=%h rd=%0d imm=%h want all 0", out_valid, stall_cnt, out_pc, out_rd, out_imm); end
    @(negedge clk); reset = 1; #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_busy ready=%0b want 1", in_ready); end
    edge_wait();
    n_run++; if (out_valid !== 1'b1 || out_op1 !== 32'h123) begin n_fail++; $display("FAIL postreset_fire v=%0b op1=%h want 1/123", out_valid, out_op1); end
  endtask
  initial begin
    reset = 0; out_ready = 1; rf_rd1 = 0; rf_rd2 = 0; idle();
    test_reset();
    test_raw_bypass();
    test_zero_reg();
    test_backpressure();
    test_flush();
    test_set_wins_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
